logic_op_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's two-input gate block: WIDTH-bit bitwise logic unit with run-time operation select instead of fixed parallel gate outputs.
- Two register stages with valid/ready handshakes on both sides, plus a wrapping count of delivered results.
- Sits between switch/button input logic and LED/7-seg display logic on the Basys-3 lab platform, or between any streaming producer and consumer.

---
 rtl/logic_op_pkg.sv | 17 +
 rtl/logic_op_unit.sv | 28 ++
 rtl/logic_op_pipe.sv | 96 +++++++++
 tb/tb_logic_op_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_op_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NAND  = 3'd2,
      OP_NOR   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSA = 3'd7
   } logic_op_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit bitwise operator selected at run time by a 3-bit opcode.
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (logic_op_e'(op))
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NOTA:  y = ~a;
         OP_PASSA: y = a;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipelined logic unit with a wrapping delivered-result counter.
// Define LOGIC_OP_FLAGS_EN to add registered out_zero / out_parity flags.
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [OP_W-1:0]  out_op,
   output logic [CNT_W-1:0] res_cnt
`ifdef LOGIC_OP_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_parity
`endif
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [OP_W-1:0]  s1_op;
   logic             s2_valid;
   logic             s1_en;
   logic             s2_en;
   logic [WIDTH-1:0] unit_y;

   // A stage may load whenever it is empty or its contents move on this cycle.
   assign s2_en     = !s2_valid || out_ready;
   assign s1_en     = !s1_valid || s2_en;
   assign in_ready  = rst_n && s1_en;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_en && in_valid) begin
         s1_a  <= in_a;
         s1_b  <= in_b;
         s1_op <= in_op;
      end
   end

   logic_op_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .a  (s1_a),
      .b  (s1_b),
      .op (s1_op),
      .y  (unit_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         out_y      <= '0;
         out_op     <= '0;
         res_cnt    <= '0;
`ifdef LOGIC_OP_FLAGS_EN
         out_zero   <= 1'b0;
         out_parity <= 1'b0;
`endif
      end else begin
         if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_y      <= unit_y;
               out_op     <= s1_op;
`ifdef LOGIC_OP_FLAGS_EN
               out_zero   <= (unit_y == '0);
               out_parity <= ^unit_y;
`endif
            end
         end
         if (s2_valid && out_ready) begin
            res_cnt <= res_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: directed vectors, corner sequences and a random scoreboard run.
module tb_logic_op_pipe;
   import logic_op_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic [2:0] out_op;
   logic [15:0] res_cnt;
   logic       in_ready4;
   logic       out_valid4;
   logic [7:0] out_y4;
   logic [2:0] out_op4;
   logic [3:0] res_cnt4;
`ifdef LOGIC_OP_FLAGS_EN
   logic       out_zero;
   logic       out_parity;
   logic       out_zero4;
   logic       out_parity4;
`endif

   int checks = 0;
   int errors = 0;

   // Scoreboard of expected results in delivery order, plus a delivered count.
   logic [7:0]  exp_y_q[$];
   logic [2:0]  exp_op_q[$];
   int unsigned model_cnt = 0;
   logic [3:0]  truth[8];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] y;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   logic_op_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y), .out_op(out_op), .res_cnt(res_cnt)
`ifdef LOGIC_OP_FLAGS_EN
      , .out_zero(out_zero), .out_parity(out_parity)
`endif
   );

   logic_op_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
      .out_ready(out_ready), .out_y(out_y4), .out_op(out_op4), .res_cnt(res_cnt4)
`ifdef LOGIC_OP_FLAGS_EN
      , .out_zero(out_zero4), .out_parity(out_parity4)
`endif
   );

   // Reference: each result bit is looked up in the opcode's 2-input truth table indexed by {a_bit, b_bit}.
   function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      logic [7:0] r;
      logic [3:0] tt;
      tt = truth[op];
      for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyRandom(input logic v);
      applyStimulus(v, 8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)));
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b0) begin
         checkOutput("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
         exp_y_q.delete();
         exp_op_q.delete();
         model_cnt = 0;
      end else if (rst_n === 1'b1) begin
         checkOutput("res_cnt", {16'd0, res_cnt}, model_cnt & 32'hFFFF);
         checkOutput("res_cnt4", {28'd0, res_cnt4}, model_cnt & 32'hF);
         if (out_valid && out_ready) begin
            if (exp_y_q.size() == 0) begin
               checkOutput("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               checkOutput("sb_out_y", {24'd0, out_y}, {24'd0, exp_y_q.pop_front()});
               checkOutput("sb_out_op", {29'd0, out_op}, {29'd0, exp_op_q.pop_front()});
            end
            model_cnt++;
         end
         if (in_valid && in_ready) begin
            exp_y_q.push_back(ref_op(in_a, in_b, in_op));
            exp_op_q.push_back(in_op);
         end
      end
   end

   initial begin
      int acc;
      int bad;
      int cnt;
      int first;
      int last;
      logic [7:0] held_y;
      logic [7:0] first_exp;

      truth[0] = 4'b1000; truth[1] = 4'b1110; truth[2] = 4'b0111; truth[3] = 4'b0001;
      truth[4] = 4'b0110; truth[5] = 4'b1001; truth[6] = 4'b0011; truth[7] = 4'b1100;

      vecs[0] = '{8'hC5, 8'h3A, 3'd0, 8'h00};
      vecs[1] = '{8'hC5, 8'h3A, 3'd1, 8'hFF};
      vecs[2] = '{8'hC5, 8'h3A, 3'd2, 8'hFF};
      vecs[3] = '{8'hC5, 8'h3A, 3'd3, 8'h00};
      vecs[4] = '{8'hC5, 8'h3A, 3'd4, 8'hFF};
      vecs[5] = '{8'hC5, 8'h3A, 3'd5, 8'h00};
      vecs[6] = '{8'hC5, 8'h3A, 3'd6, 8'h3A};
      vecs[7] = '{8'hC5, 8'h3A, 3'd7, 8'hC5};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      tick();
      tick();
      @(negedge clk);
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_out_y", {24'd0, out_y}, 32'd0);
      checkOutput("reset_out_op", {29'd0, out_op}, 32'd0);
      checkOutput("reset_res_cnt", {16'd0, res_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
      tick();

      $display("[TB] opcode sweep");
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
         else       applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
         @(negedge clk);
         if (i >= 2) begin
            checkOutput($sformatf("sweep_valid_%0d", i - 2), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("sweep_y_op%0d", i - 2), {24'd0, out_y}, {24'd0, vecs[i - 2].y});
            checkOutput($sformatf("sweep_op_%0d", i - 2), {29'd0, out_op}, {29'd0, vecs[i - 2].op});
         end
         tick();
      end
      @(negedge clk);
      checkOutput("sweep_res_cnt", {16'd0, res_cnt}, 32'd8);
      tick();

      $display("[TB] back-to-back stream");
      bad = 0; cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 18; i++) begin
         applyRandom(i < 16);
         @(negedge clk);
         if (i < 16 && !in_ready) bad++;
         if (out_valid) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
         tick();
      end
      checkOutput("b2b_in_ready_drops", bad, 0);
      checkOutput("b2b_out_count", cnt, 16);
      checkOutput("b2b_first_out", first, 2);
      checkOutput("b2b_contiguous", last - first, 15);

      $display("[TB] output stall");
      out_ready = 1'b0;
      acc = 0; bad = 0; held_y = 8'h00; first_exp = 8'h00;
      for (int i = 0; i < 5; i++) begin
         applyRandom(1'b1);
         if (i == 0) first_exp = ref_op(in_a, in_b, in_op);
         @(negedge clk);
         if (in_ready) acc++;
         if (i == 2) held_y = out_y;
         if (i > 2 && out_y !== held_y) bad++;
         if (i == 4) begin
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
         end
         tick();
      end
      checkOutput("stall_accepted", acc, 2);
      checkOutput("stall_first_result", {24'd0, held_y}, {24'd0, first_exp});
      checkOutput("stall_y_changed", bad, 0);
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checkOutput("stall_drained", exp_y_q.size(), 0);
      checkOutput("stall_res_cnt", {16'd0, res_cnt}, 32'd26);
      tick();

`ifdef LOGIC_OP_FLAGS_EN
      $display("[TB] flag outputs");
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       applyStimulus(1'b1, 8'h5A, 8'h5A, 3'd4);
            1:       applyStimulus(1'b1, 8'h01, 8'h02, 3'd1);
            2:       applyStimulus(1'b1, 8'h07, 8'h00, 3'd7);
            default: applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
         endcase
         @(negedge clk);
         if (i == 2) begin
            checkOutput("flag_xor_y", {24'd0, out_y}, 32'h00);
            checkOutput("flag_xor_zero", {31'd0, out_zero}, 32'd1);
            checkOutput("flag_xor_parity", {31'd0, out_parity}, 32'd0);
         end else if (i == 3) begin
            checkOutput("flag_or_y", {24'd0, out_y}, 32'h03);
            checkOutput("flag_or_zero", {31'd0, out_zero}, 32'd0);
            checkOutput("flag_or_parity", {31'd0, out_parity}, 32'd0);
         end else if (i == 4) begin
            checkOutput("flag_pass_parity", {31'd0, out_parity}, 32'd1);
            checkOutput("flag_pass_zero", {31'd0, out_zero}, 32'd0);
         end
         tick();
      end
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyRandom(1'($urandom_range(1, 0)));
         out_ready = 1'($urandom_range(3, 0) != 0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checkOutput("random_drained", exp_y_q.size(), 0);
      tick();

      $display("[TB] reset with both stages full");
      out_ready = 1'b0;
      applyRandom(1'b1);
      tick();
      applyRandom(1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      @(negedge clk);
      checkOutput("prereset_full", {31'd0, in_ready}, 32'd0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midreset_res_cnt", {16'd0, res_cnt}, 32'd0);
      checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         if (out_valid) cnt++;
      end
      checkOutput("midreset_ghost_outputs", cnt, 0);
      tick();

      $display("[TB] narrow counter wrap");
      for (int k = 1; k <= 17; k++) begin
         applyRandom(1'b1);
         tick();
         applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
         repeat (3) tick();
         @(negedge clk);
         if (k == 15) checkOutput("wrap_after_15", {28'd0, res_cnt4}, 32'hF);
         if (k == 16) checkOutput("wrap_after_16", {28'd0, res_cnt4}, 32'h0);
         if (k == 17) begin
            checkOutput("wrap_after_17", {28'd0, res_cnt4}, 32'h1);
            checkOutput("wide_after_17", {16'd0, res_cnt}, 32'd17);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
